// File: rtl/puf_challenge_sequencer.sv
// Sweeps PUF challenges 0..15. Each challenge is reset, settled, sampled
// NUM_VOTES times and majority-voted per bit, then handed out on a valid/ready port.
module puf_challenge_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned NUM_VOTES     = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       puf_reset,
    output logic       puf_start,
    output logic [3:0] puf_addr,
    input  logic [7:0] puf_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_addr,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, PRESET, SETTLE, SAMPLE, EMIT} state_e;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] VOTE_LAST   = 8'(NUM_VOTES - 1);
    localparam logic [3:0] HALF        = 4'(NUM_VOTES / 2);

    state_e          state_q, state_d;
    logic [3:0]      addr_q, addr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0][3:0] ones_q, ones_d;
    logic            done_q, done_d;
    logic            kill_q, kill_d;
    logic [7:0]      vote;

    for (genvar i = 0; i < 8; i++) begin : g_vote
        assign vote[i] = (ones_q[i] > HALF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            ones_q  <= '0;
            done_q  <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
            done_q  <= done_d;
            kill_q  <= kill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        ones_d  = ones_q;
        done_d  = 1'b0;
        kill_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    addr_d  = '0;
                    cnt_d   = '0;
                    ones_d  = '0;
                    state_d = PRESET;
                end
            end
            PRESET: begin
                cnt_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SAMPLE: begin
                for (int i = 0; i < 8; i++) begin
                    ones_d[i] = ones_q[i] + {3'b000, puf_out[i]};
                end
                if (cnt_q == VOTE_LAST) begin
                    cnt_d   = '0;
                    state_d = EMIT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            EMIT: begin
                if (rsp_ready) begin
                    ones_d = '0;
                    if (addr_q == 4'hF) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + 4'd1;
                        state_d = PRESET;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides everything, including a transfer in the same cycle.
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
            ones_d  = '0;
            done_d  = 1'b0;
            kill_d  = 1'b1;
        end
    end

    assign busy      = (state_q != IDLE);
    assign puf_reset = (state_q == PRESET) || kill_q;
    assign puf_start = (state_q == SETTLE) || (state_q == SAMPLE);
    assign puf_addr  = addr_q;
    assign rsp_valid = (state_q == EMIT);
    assign rsp_addr  = addr_q;
    assign rsp_data  = (state_q == EMIT) ? vote : 8'h00;
    assign done      = done_q;

endmodule
